// File: rtl/iob_mem_arbiter.sv
// -----------------------------------------------------------------------------
// iob_mem_arbiter
//   Round-robin arbiter sharing one IOb native slave port between N_MASTERS IOb
//   native masters. The winning request is captured into holding registers and
//   presented to the slave unchanged until the slave returns ready. The ready
//   and read data are routed back only to the granted master. One transaction
//   is outstanding at a time, with one idle cycle between transactions.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   m_req   in   N_MASTERS x {valid, addr, wdata, wstrb}, master 0 at the LSBs
//   m_resp  out  N_MASTERS x {rdata, ready}, master 0 at the LSBs
//   s_req   out  {valid, addr, wdata, wstrb} toward the shared slave
//   s_resp  in   {rdata, ready} from the shared slave
//   grant   out  one-hot current owner, all-zero when idle
// -----------------------------------------------------------------------------
module iob_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [N_MASTERS*(1+ADDR_W+DATA_W+DATA_W/8)-1:0]     m_req,
  output logic [N_MASTERS*(DATA_W+1)-1:0]                     m_resp,
  output logic [(1+ADDR_W+DATA_W+DATA_W/8)-1:0]               s_req,
  input  logic [DATA_W:0]                                     s_resp,
  output logic [N_MASTERS-1:0]                                grant
);

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W = DATA_W + 1;
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]   held_addr;
  logic [DATA_W-1:0]   held_wdata;
  logic [STRB_W-1:0]   held_wstrb;

  logic                s_ready;
  logic [DATA_W-1:0]   s_rdata;
  logic [N_MASTERS-1:0] m_valid;
  logic [REQ_W-1:0]    req_arr [N_MASTERS];

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      cand;

  assign s_ready = s_resp[0];
  assign s_rdata = s_resp[RESP_W-1:1];

  // Per-master unpacking of requests and routing of the response. Only the
  // owner sees ready, and only while a transaction is actually in flight, so
  // a stray slave ready while idle never reaches any master.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_master
    assign req_arr[i] = m_req[i*REQ_W +: REQ_W];
    assign m_valid[i] = req_arr[i][REQ_W-1];
    assign m_resp[i*RESP_W +: RESP_W] =
      (state == BUSY && grant[i] && s_ready) ? {s_rdata, 1'b1} : '0;
  end

  // Slave request comes straight from the holding registers, so the fields
  // stay frozen for the whole transaction even if the master misbehaves.
  assign s_req = (state == BUSY) ? {1'b1, held_addr, held_wdata, held_wstrb} : '0;

  // Round-robin search starting one past the last served master. cand is one
  // bit wider than an index so last+k can exceed N-1 before being folded back,
  // which keeps the wrap correct for non-power-of-two N.
  always_comb begin
    // NOTE: every variable gets a default before any conditional logic so the
    // block stays purely combinational; a missing default would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = {1'b0, last} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_MASTERS)) begin
        cand = cand - (IDX_W+1)'(N_MASTERS);
      end
      if (!win_found && m_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= IDX_W'(N_MASTERS - 1);
      gnt_idx    <= '0;
      grant      <= '0;
      // NOTE: the holding registers are ordinary flops, not a memory, so they
      // are reset along with the control state to keep post-reset contents known.
      held_addr  <= '0;
      held_wdata <= '0;
      held_wstrb <= '0;
    end else begin
      // NOTE: non-blocking assignments only here; every flop samples the
      // pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (win_found) begin
            held_addr  <= req_arr[win_idx][REQ_W-2 -: ADDR_W];
            held_wdata <= req_arr[win_idx][STRB_W +: DATA_W];
            held_wstrb <= req_arr[win_idx][STRB_W-1:0];
            gnt_idx    <= win_idx;
            grant      <= N_MASTERS'(1) << win_idx;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (s_ready) begin
            last  <= gnt_idx;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iob_mem_arbiter
//   Directed bench for iob_mem_arbiter with N_MASTERS=2, 32-bit address/data.
//   A transaction-level model (owner/last/held request) predicts s_req, grant
//   and m_resp, and a compare process checks them on every falling edge.
//   Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_iob_mem_arbiter;

  localparam int N      = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int REQ_W  = 1 + AW + DW + DW/8;
  localparam int RESP_W = DW + 1;

  logic                  clk;
  logic                  rst;
  logic [N*REQ_W-1:0]    m_req;
  logic [N*RESP_W-1:0]   m_resp;
  logic [REQ_W-1:0]      s_req;
  logic [RESP_W-1:0]     s_resp;
  logic [N-1:0]          grant;

  int checks   = 0;
  int failures = 0;

  logic [N*RESP_W-1:0]   cap_mresp;
  logic [N-1:0]          cap_grant;

  iob_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .grant  (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual=running required=finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    m_req[i*REQ_W +: REQ_W] = {v, a, d, s};
  endtask

  task automatic drop_req(input int i);
    m_req[i*REQ_W + REQ_W - 1] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Wait (bounded) until the slave sees a valid request.
  task automatic wait_svalid();
    int n;
    n = 0;
    while (!s_req[REQ_W-1] && n < 20) begin
      tick();
      n++;
    end
    check("svalid_wait", 128'(s_req[REQ_W-1]), 128'(1'b1));
  endtask

  // Slave answers in the hold-th cycle of valid; captures m_resp/grant in the
  // ready cycle and checks the mandatory idle cycle afterwards.
  task automatic slave_respond(input int hold, input logic [31:0] rd);
    wait_svalid();
    repeat (hold - 1) tick();
    s_resp = {rd, 1'b1};
    #1;
    cap_mresp = m_resp;
    cap_grant = grant;
    tick();
    s_resp = '0;
    check("idle_gap_s_valid", 128'(s_req[REQ_W-1]), 128'(1'b0));
    check("idle_gap_grant", 128'(grant), 128'(2'b00));
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model + per-cycle compare
  // ---------------------------------------------------------------------------
  initial begin : compare
    int                  owner;
    int                  lastm;
    logic [REQ_W-1:0]    held;
    logic [REQ_W-1:0]    exp_sreq;
    logic [N-1:0]        exp_grant;
    logic [N*RESP_W-1:0] exp_mresp;
    owner = -1;
    lastm = N - 1;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        owner = -1;
        lastm = N - 1;
      end
      exp_sreq  = '0;
      exp_grant = '0;
      exp_mresp = '0;
      if (owner >= 0) begin
        exp_sreq  = held;
        exp_grant = N'(1) << owner;
        if (s_resp[0]) exp_mresp[owner*RESP_W +: RESP_W] = {s_resp[RESP_W-1:1], 1'b1};
      end
      check("cmp_s_req", 128'(s_req), 128'(exp_sreq));
      check("cmp_grant", 128'(grant), 128'(exp_grant));
      check("cmp_m_resp", 128'(m_resp), 128'(exp_mresp));
      @(posedge clk);
      if (!rst) begin
        owner = -1;
        lastm = N - 1;
      end else if (owner >= 0) begin
        if (s_resp[0]) begin
          lastm = owner;
          owner = -1;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (lastm + k) % N;
          if (owner < 0 && m_req[c*REQ_W + REQ_W - 1]) begin
            owner = c;
            held  = m_req[c*REQ_W +: REQ_W];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [1:0] fair_exp [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin : stim
    rst    = 1'b0;
    m_req  = '0;
    s_resp = '0;
    tick();
    check("reset_s_req", 128'(s_req), 128'(0));
    check("reset_m_resp", 128'(m_resp), 128'(0));
    check("reset_grant", 128'(grant), 128'(0));
    tick();
    rst = 1'b1;

    // Single master read.
    set_req(0, 1'b1, 32'h100, 32'h0, 4'h0);
    tick();
    check("single_grant", 128'(grant), 128'(2'b01));
    for (int c = 0; c < 3; c++) begin
      check("single_addr_held", 128'(s_req[REQ_W-2 -: AW]), 128'(32'h100));
      if (c < 2) tick();
    end
    slave_respond(1, 32'hDEADBEEF);
    drop_req(0);
    check("single_m0_resp", 128'(cap_mresp[0 +: RESP_W]), 128'({32'hDEADBEEF, 1'b1}));
    check("single_m1_resp", 128'(cap_mresp[RESP_W +: RESP_W]), 128'(0));

    // Simultaneous requests after reset: master 0 first, then master 1.
    do_reset();
    set_req(0, 1'b1, 32'h40, 32'h11223344, 4'hF);
    set_req(1, 1'b1, 32'h200, 32'h0, 4'h0);
    wait_svalid();
    check("simul_first_grant", 128'(grant), 128'(2'b01));
    check("simul_write_req", 128'(s_req), 128'({1'b1, 32'h40, 32'h11223344, 4'hF}));
    slave_respond(2, 32'h0);
    drop_req(0);
    check("simul_m0_ready", 128'(cap_mresp[0]), 128'(1'b1));
    tick();
    check("simul_second_grant", 128'(grant), 128'(2'b10));
    check("simul_read_addr", 128'(s_req[REQ_W-2 -: AW]), 128'(32'h200));
    slave_respond(1, 32'hCAFE0001);
    drop_req(1);
    check("simul_m1_resp", 128'(cap_mresp[RESP_W +: RESP_W]), 128'({32'hCAFE0001, 1'b1}));
    check("simul_m0_quiet", 128'(cap_mresp[0 +: RESP_W]), 128'(0));

    // Fairness: both masters request continuously.
    do_reset();
    set_req(0, 1'b1, 32'h1000, 32'hA0A0A0A0, 4'h3);
    set_req(1, 1'b1, 32'h2000, 32'h0, 4'h0);
    for (int t = 0; t < 6; t++) begin
      slave_respond(1, 32'(t));
      check("fair_grant_seq", 128'(cap_grant), 128'(fair_exp[t]));
    end
    drop_req(0);
    drop_req(1);

    // Granted master 1 drops valid early; transaction completes from held fields.
    tick();
    set_req(1, 1'b1, 32'h300, 32'h55AA55AA, 4'h1);
    wait_svalid();
    check("drop_grant", 128'(grant), 128'(2'b10));
    tick();
    drop_req(1);
    for (int c = 0; c < 3; c++) begin
      check("drop_req_held", 128'(s_req), 128'({1'b1, 32'h300, 32'h55AA55AA, 4'h1}));
      tick();
    end
    slave_respond(1, 32'h0BADF00D);
    check("drop_m1_ready", 128'(cap_mresp[RESP_W +: RESP_W]), 128'({32'h0BADF00D, 1'b1}));
    check("drop_grant_cleared", 128'(grant), 128'(0));
    check("drop_single_pulse", 128'(m_resp), 128'(0));

    // Spurious ready while idle.
    tick();
    s_resp = {32'h12345678, 1'b1};
    #1;
    check("spurious_m_resp", 128'(m_resp), 128'(0));
    tick();
    check("spurious_grant", 128'(grant), 128'(0));
    check("spurious_s_valid", 128'(s_req[REQ_W-1]), 128'(1'b0));
    s_resp = '0;

    // Reset asserted mid-transaction.
    tick();
    set_req(0, 1'b1, 32'h400, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h500, 32'h0, 4'h0);
    wait_svalid();
    tick();
    #2;
    rst    = 1'b0;
    s_resp = {32'hFFFFFFFF, 1'b1};
    #1;
    check("async_rst_s_req", 128'(s_req), 128'(0));
    check("async_rst_m_resp", 128'(m_resp), 128'(0));
    check("async_rst_grant", 128'(grant), 128'(0));
    tick();
    s_resp = '0;
    tick();
    rst = 1'b1;
    wait_svalid();
    check("post_rst_grant", 128'(grant), 128'(2'b01));
    check("post_rst_addr", 128'(s_req[REQ_W-2 -: AW]), 128'(32'h400));
    slave_respond(1, 32'h77);
    drop_req(0);
    drop_req(1);
    check("post_rst_m0_ready", 128'(cap_mresp[0 +: RESP_W]), 128'({32'h77, 1'b1}));
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
